// File: rtl/ysyx_040066_clint_pkg.sv
// Shared CLINT register map, window geometry and byte-lane helpers.
// Offsets are relative to the 64 KiB window base.
package ysyx_040066_clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam int unsigned WINDOW_BYTES = 65536;
  localparam int unsigned MAX_HART     = 8;

  function automatic logic [63:0] byte_mask(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/ysyx_040066_clint_timer.sv
// Prescaler plus free-running 64-bit mtime counter.
// A load overrides the same-cycle increment and restarts the prescaler.
module ysyx_040066_clint_timer
  import ysyx_040066_clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic [7:0]  mask,
  output logic        tick,
  output logic [63:0] mtime
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] bmask;

  assign tick  = (presc_q == PRESC_MAX);
  assign mtime = mtime_q;

  always_comb begin
    bmask   = byte_mask(mask);
    presc_d = presc_q + 16'd1;
    mtime_d = mtime_q;
    if (load) begin
      presc_d = '0;
      mtime_d = (mtime_q & ~bmask) | (load_data & bmask);
    end else if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

endmodule

// File: rtl/ysyx_040066_clint_mh.sv
// Multi-hart CLINT: msip/mtimecmp per hart, shared mtime, single-cycle
// registered response for every in-window access.
module ysyx_040066_clint_mh
  import ysyx_040066_clint_pkg::*;
#(
  parameter int unsigned NHART    = 2,
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRd,
  input  logic             MemWr,
  input  logic [63:0]      addr,
  input  logic [63:0]      data_Wr,
  input  logic [7:0]       wr_mask,
  output logic             MemRd_real,
  output logic             MemWr_real,
  output logic             hit,
  output logic [63:0]      data_rd,
  output logic             ack,
  output logic             error,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  localparam int WIN_W = $clog2(WINDOW_BYTES);

  logic        in_win, win_req, bad, wr_ok, rd_ok;
  logic [15:0] off, msip_rel, mtc_rel;
  logic [2:0]  msip_idx, mtc_idx;
  logic        msip_sel, mtc_sel, mtime_sel;
  logic [63:0] wmask64, rd_data, mtime;
  logic [63:0] cmp_all [NHART];
  logic        tick_unused;

  logic        ack_q, hit_q, err_q;
  logic [63:0] data_rd_q;

  assign in_win     = (addr[63:WIN_W] == BASE[63:WIN_W]);
  assign MemRd_real = MemRd & ~in_win;
  assign MemWr_real = MemWr & ~in_win;
  assign win_req    = in_win & (MemRd | MemWr);

  assign off      = addr[15:0];
  assign msip_rel = off - MSIP_OFF;
  assign mtc_rel  = off - MTIMECMP_OFF;
  assign msip_idx = msip_rel[4:2];
  assign mtc_idx  = mtc_rel[5:3];

  // Offsets past the last implemented hart decode as unmapped, hence error.
  assign msip_sel  = (msip_rel < 16'(4 * MAX_HART)) && (32'(msip_idx) < NHART)
                     && (off[1:0] == 2'b00);
  assign mtc_sel   = (mtc_rel < 16'(8 * MAX_HART)) && (32'(mtc_idx) < NHART)
                     && (off[2:0] == 3'b000);
  assign mtime_sel = (off == MTIME_OFF);

  assign bad     = (MemRd & MemWr) | ~(msip_sel | mtc_sel | mtime_sel);
  assign wr_ok   = win_req & MemWr & ~bad;
  assign rd_ok   = win_req & MemRd & ~bad;
  assign wmask64 = byte_mask(wr_mask);

  ysyx_040066_clint_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (wr_ok & mtime_sel),
    .load_data (data_Wr),
    .mask      (wr_mask),
    .tick      (tick_unused),
    .mtime     (mtime)
  );

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    logic [63:0] cmp_q, cmp_d;
    logic        sip_q, sip_d, tip_q;

    always_comb begin
      cmp_d = cmp_q;
      sip_d = sip_q;
      if (wr_ok && mtc_sel && (mtc_idx == 3'(h)))
        cmp_d = (cmp_q & ~wmask64) | (data_Wr & wmask64);
      if (wr_ok && msip_sel && (msip_idx == 3'(h))) begin
        if (off[2]) begin
          if (wr_mask[4]) sip_d = data_Wr[32];
        end else begin
          if (wr_mask[0]) sip_d = data_Wr[0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cmp_q <= '1;
        sip_q <= 1'b0;
        tip_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        sip_q <= sip_d;
        tip_q <= (mtime >= cmp_q);
      end
    end

    assign cmp_all[h] = cmp_q;
    assign mtip[h]    = tip_q;
    assign msip[h]    = sip_q;
  end

  // mtime is read pre-tick: the counter register, not its next value.
  always_comb begin
    rd_data = '0;
    if (mtime_sel) rd_data = mtime;
    for (int h = 0; h < NHART; h++) begin
      if (mtc_sel && (mtc_idx == 3'(h))) rd_data = cmp_all[h];
      if (msip_sel && (msip_idx == 3'(h)))
        rd_data = off[2] ? {31'd0, msip[h], 32'd0} : {63'd0, msip[h]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      data_rd_q <= '0;
    end else begin
      ack_q <= win_req;
      hit_q <= win_req;
      err_q <= win_req & bad;
      if (win_req) data_rd_q <= rd_ok ? rd_data : '0;
    end
  end

  assign ack     = ack_q;
  assign hit     = hit_q;
  assign error   = err_q;
  assign data_rd = data_rd_q;

endmodule

// File: tb/tb_ysyx_040066_clint_mh.sv
// Directed bench: one CLINT with PRESCALE=4 (a_*) and one with PRESCALE=1 (b_*)
// share the bus; expected values are hand-computed per step.
module tb_ysyx_040066_clint_mh;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRd = 1'b0, MemWr = 1'b0;
  logic [63:0] addr = '0, data_Wr = '0;
  logic [7:0]  wr_mask = '0;

  logic        a_MemRd_real, a_MemWr_real, a_hit, a_ack, a_error;
  logic [63:0] a_data_rd;
  logic [1:0]  a_mtip, a_msip;

  logic        b_MemRd_real_unused, b_MemWr_real_unused, b_hit_unused, b_ack_unused, b_error;
  logic [63:0] b_data_rd;
  logic [1:0]  b_mtip, b_msip_unused;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_040066_clint_mh #(.NHART(2), .BASE(BASE), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .addr(addr),
    .data_Wr(data_Wr), .wr_mask(wr_mask),
    .MemRd_real(a_MemRd_real), .MemWr_real(a_MemWr_real), .hit(a_hit),
    .data_rd(a_data_rd), .ack(a_ack), .error(a_error), .mtip(a_mtip), .msip(a_msip)
  );

  ysyx_040066_clint_mh #(.NHART(2), .BASE(BASE), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .addr(addr),
    .data_Wr(data_Wr), .wr_mask(wr_mask),
    .MemRd_real(b_MemRd_real_unused), .MemWr_real(b_MemWr_real_unused), .hit(b_hit_unused),
    .data_rd(b_data_rd), .ack(b_ack_unused), .error(b_error), .mtip(b_mtip), .msip(b_msip_unused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [63:0] a,
                     input logic [63:0] d, input logic [7:0] m);
    MemRd = rd; MemWr = wr; addr = a; data_Wr = d; wr_mask = m;
    @(posedge clk); #1;
    MemRd = 1'b0; MemWr = 1'b0; addr = '0; data_Wr = '0; wr_mask = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    check("rst_ack",   64'(a_ack),     64'd0);
    check("rst_hit",   64'(a_hit),     64'd0);
    check("rst_err",   64'(a_error),   64'd0);
    check("rst_data",  a_data_rd,      64'd0);
    check("rst_mtip",  64'(a_mtip),    64'd0);
    check("rst_msip",  64'(a_msip),    64'd0);
    rst = 1'b1;

    // edge 1: mtimecmp[1] = 10
    req(0, 1, BASE + 64'h4008, 64'd10, 8'hFF);
    check("cmp_wr_ack", 64'(a_ack),   64'd1);
    check("cmp_wr_hit", 64'(a_hit),   64'd1);
    check("cmp_wr_err", 64'(a_error), 64'd0);

    // edges 2..7, then read mtime on edge 8 (a: tick edge, pre-tick value 1; b: 7)
    idle(6);
    req(1, 0, BASE + 64'hBFF8, 64'd0, 8'h00);
    check("mtime_rd_a", a_data_rd, 64'd1);
    check("mtime_rd_b", b_data_rd, 64'd7);
    idle(1);
    check("ack_one_cycle", 64'(a_ack), 64'd0);
    check("hit_one_cycle", 64'(a_hit), 64'd0);

    // edges 10..40: mtime reaches 10 on edge 40, mtip[1] follows on edge 41
    idle(31);
    check("mtip_before", 64'(a_mtip), 64'd0);
    idle(1);
    check("mtip_rise",   64'(a_mtip), 64'b10);
    check("mtip_b",      64'(b_mtip), 64'b10);

    req(1, 0, BASE + 64'h4008, 64'd0, 8'h00);
    check("cmp_rd",     a_data_rd,       64'd10);
    check("cmp_rd_err", 64'(a_error),    64'd0);

    // software interrupts
    req(0, 1, BASE + 64'h4, 64'h0000_0001_0000_0000, 8'hF0);
    check("msip1_ack", 64'(a_ack),  64'd1);
    check("msip1_set", 64'(a_msip), 64'b10);
    req(1, 0, BASE + 64'h4, 64'd0, 8'h00);
    check("msip1_rd",  a_data_rd,   64'h0000_0001_0000_0000);
    req(0, 1, BASE, 64'd1, 8'h0F);
    check("msip0_set", 64'(a_msip), 64'b11);
    req(0, 1, BASE, 64'd0, 8'h00);
    check("msip_nomask", 64'(a_msip), 64'b11);
    req(1, 0, BASE, 64'd0, 8'h00);
    check("msip0_rd",  a_data_rd,   64'd1);

    // faulting accesses
    req(1, 0, BASE + 64'h4003, 64'd0, 8'h00);
    check("misal_ack",  64'(a_ack),   64'd1);
    check("misal_err",  64'(a_error), 64'd1);
    check("misal_data", a_data_rd,    64'd0);
    req(1, 0, BASE + 64'h4010, 64'd0, 8'h00);
    check("hart2_err",  64'(a_error), 64'd1);
    check("hart2_hit",  64'(a_hit),   64'd1);
    req(1, 1, BASE, 64'd0, 8'hFF);
    check("rdwr_err",   64'(a_error), 64'd1);
    check("rdwr_msip",  64'(a_msip),  64'b11);
    req(0, 1, BASE + 64'h400C, 64'd0, 8'hFF);
    check("misal_wr_err", 64'(a_error), 64'd1);
    req(1, 0, BASE + 64'h4008, 64'd0, 8'h00);
    check("cmp_kept",   a_data_rd,    64'd10);
    check("mtip_kept",  64'(a_mtip),  64'b10);
    req(1, 0, BASE + 64'h1000, 64'd0, 8'h00);
    check("unmap_err",  64'(a_error), 64'd1);
    check("unmap_data", a_data_rd,    64'd0);

    // mtime wrap on the PRESCALE=1 instance
    req(0, 1, BASE + 64'h4000, 64'd5, 8'hFF);
    req(0, 1, BASE + 64'h4008, 64'd5, 8'hFF);
    req(0, 1, BASE + 64'hBFF8, ONES, 8'hFF);
    req(1, 0, BASE + 64'hBFF8, 64'd0, 8'h00);
    check("wrap_pre_b",  b_data_rd,    ONES);
    check("wrap_pre_a",  a_data_rd,    ONES);
    check("wrap_mtip_b", 64'(b_mtip),  64'b11);
    req(1, 0, BASE + 64'hBFF8, 64'd0, 8'h00);
    check("wrap_zero_b", b_data_rd,    64'd0);
    check("wrap_err_b",  64'(b_error), 64'd0);
    check("wrap_mtip0",  64'(b_mtip),  64'b00);
    check("presc_hold_a", a_data_rd,   ONES);
    check("mtip_a_ones", 64'(a_mtip),  64'b11);

    // out-of-window traffic
    MemRd = 1'b1; addr = 64'h8000_0000; #1;
    check("rd_real",  64'(a_MemRd_real), 64'd1);
    check("wr_real0", 64'(a_MemWr_real), 64'd0);
    @(posedge clk); #1;
    MemRd = 1'b0;
    check("oow_ack", 64'(a_ack), 64'd0);
    check("oow_hit", 64'(a_hit), 64'd0);
    MemWr = 1'b1; addr = 64'h8000_0000; #1;
    check("wr_real", 64'(a_MemWr_real), 64'd1);
    MemWr = 1'b0; MemRd = 1'b1; addr = BASE; #1;
    check("rd_real_inwin", 64'(a_MemRd_real), 64'd0);
    @(posedge clk); #1;
    MemRd = 1'b0; addr = '0;

    // reset asserted in the middle of an in-window store
    MemWr = 1'b1; addr = BASE + 64'h4000; data_Wr = 64'd0; wr_mask = 8'hFF;
    #2; rst = 1'b0;
    @(posedge clk); #1;
    MemWr = 1'b0; addr = '0; wr_mask = '0;
    check("mid_rst_ack",  64'(a_ack),   64'd0);
    check("mid_rst_hit",  64'(a_hit),   64'd0);
    check("mid_rst_err",  64'(a_error), 64'd0);
    check("mid_rst_data", a_data_rd,    64'd0);
    check("mid_rst_mtip", 64'(a_mtip),  64'd0);
    check("mid_rst_msip", 64'(a_msip),  64'd0);
    rst = 1'b1;
    idle(1);
    check("post_rst_ack", 64'(a_ack), 64'd0);
    req(1, 0, BASE + 64'h4000, 64'd0, 8'h00);
    check("post_rst_cmp", a_data_rd, ONES);
    check("post_rst_mtip", 64'(a_mtip), 64'd0);
    req(1, 0, BASE + 64'hBFF8, 64'd0, 8'h00);
    check("post_rst_mtime", a_data_rd, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_040066_clint_mh.md
YSYX_040066_CLINT_MH -- requirements
Module: ysyx_040066_clint_mh

Interface
REQ-001 SHALL: parameter NHART, default 2, number of harts served (1..8).
REQ-002 SHALL: parameter BASE, default 64'h0200_0000, CLINT window base (64 KiB window).
REQ-003 SHALL: parameter PRESCALE, default 1, clk cycles per mtime tick (1..65535).
REQ-004 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL: rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL: MemRd  input  1  load request, one-cycle pulse.
REQ-007 SHALL: MemWr  input  1  store request, one-cycle pulse.
REQ-008 SHALL: addr  input  64  byte address of request.
REQ-009 SHALL: data_Wr  input  64  store data, lane-aligned to addr[2:0].
REQ-010 SHALL: wr_mask  input  8  store byte enables.
REQ-011 SHALL: MemRd_real, MemWr_real  output  1 each  request forwarded to memory (outside window).
REQ-012 SHALL: hit  output  1  registered; previous-cycle request targeted the window.
REQ-013 SHALL: data_rd  output  64  registered read data.
REQ-014 SHALL: ack  output  1  registered; completes a window access.
REQ-015 SHALL: error  output  1  registered; window access faulted, valid with ack.
REQ-016 SHALL: mtip  output  NHART  per-hart timer interrupt, registered.
REQ-017 SHALL: msip  output  NHART  per-hart software interrupt, registered.

Function
REQ-018 SHALL: decode in-window as addr[63:16]==BASE[63:16]; MemRd_real/MemWr_real = request AND NOT in-window, combinational.
REQ-019 SHALL: map msip[h] at offset 4*h (32-bit, bit0 only, others read 0); mtimecmp[h] at 0x4000+8*h (64-bit); mtime at 0xBFF8 (64-bit).
REQ-020 SHALL: complete every in-window access one cycle after request: ack=1, hit=1 for exactly one cycle.
REQ-021 SHALL: in-window, unmapped offset, hart index >= NHART, misalignment (64-bit reg with addr[2:0]!=0, msip with addr[1:0]!=0), or MemRd&&MemWr together -> ack=1, error=1, data_rd=0, no state change.
REQ-022 SHALL: writes honour wr_mask per byte; read data returned lane-aligned (msip in lanes addr[2]?7:4 : 3:0).
REQ-023 SHALL: prescaler counts 0..PRESCALE-1; mtime += 1 on wrap; PRESCALE=1 ticks every cycle.
REQ-024 SHALL: mtime wraps 2^64-1 -> 0 without fault.
REQ-025 SHALL: write to mtime in a tick cycle takes write value (no increment); prescaler reset to 0 on any mtime write.
REQ-026 SHALL: mtip[h] <= (mtime >= mtimecmp[h]) unsigned, evaluated on post-update values, one-cycle latency after mtime/mtimecmp change.
REQ-027 SHALL: read of mtime returns value before same-cycle tick.
REQ-028 SHALL: msip[h] follows stored bit0 register directly.
REQ-029 SHALL: out-of-window requests produce no ack/hit/error.

Reset
REQ-030 SHALL: on rst low: mtime=0, prescaler=0, mtimecmp[*]=all-ones, msip[*]=0, mtip=0, data_rd=0, ack=0, hit=0, error=0.
REQ-031 SHALL: a request coincident with reset assertion is dropped; no ack after release.
REQ-032 SHALL: reset release synchronous to clk edge handling is the integrator's concern; block makes no assumption beyond async assert.

Structure
REQ-033 SHALL: offsets (MSIP_OFF, MTIMECMP_OFF, MTIME_OFF), window size and max hart count live in package ysyx_040066_clint_pkg.
REQ-034 SHALL: prescaler+mtime counter in one sub-module ysyx_040066_clint_timer (ports: tick, load, load_data, mask, mtime).
REQ-035 SHALL: mtimecmp/msip arrays generated per hart with generate loop; no latches.

Verification
REQ-036 SHALL: NHART=2, PRESCALE=4, write mtimecmp[1]=10 -> mtip[1] rises exactly one cycle after mtime reaches 10 (cycle ~41 after reset), mtip[0] stays 0.
REQ-037 SHALL: store 1 to BASE+4 -> next cycle ack=1, msip=2'b10; load BASE+4 -> data_rd[63:32]=1.
REQ-038 SHALL: write mtime=64'hFFFF_FFFF_FFFF_FFFF with PRESCALE=1 -> next tick mtime=0, mtip of any hart with mtimecmp=5 deasserts.
REQ-039 SHALL: load BASE+0x4003, load BASE+0x4010 (NHART=2), MemRd&&MemWr to BASE -> each ack=1, error=1, data_rd=0, state unchanged.
REQ-040 SHALL: load addr 64'h8000_0000 -> MemRd_real=1 same cycle, hit=0, ack=0; assert rst mid in-window access -> all outputs reset values, mtimecmp=all-ones.
